// File: rtl/arbitro_demux_8_32.sv
// Round-robin byte arbiter that shares one 8-bit stream into the 8->32 demux among NUM_LANES byte sources.
// Latency: request-to-grant 1 cycle, accept-to-output 1 cycle; words from different lanes go out back to back with no gap.
// Backpressure: a byte is accepted only when its lane is granted and valid; sources hold their byte until granted, and a mid-word withdraw aborts the word.
module arbitro_demux_8_32 #(
   parameter int NUM_LANES      = 4,
   parameter int BYTES_PER_WORD = 4,
   parameter int LANE_W         = 2
) (
   input  logic                   clk_4f,
   input  logic                   reset,
   input  logic [NUM_LANES-1:0]   valid_lane,
   input  logic [8*NUM_LANES-1:0] data_lane,
   output logic [NUM_LANES-1:0]   grant_lane,
   output logic [7:0]             data_arb,
   output logic                   valid_arb,
   output logic [LANE_W-1:0]      lane_arb,
   output logic                   sow_arb,
   output logic                   abort_arb
);

   localparam int                CNT_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [LANE_W-1:0] RESET_LAST = LANE_W'(NUM_LANES - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LANE_W-1:0]      last_q, last_d;
   logic [LANE_W-1:0]      gidx_q, gidx_d;
   logic [NUM_LANES-1:0]   grant_q, grant_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic [LANE_W-1:0]      lane_q, lane_d;
   logic                   sow_q, sow_d;
   logic                   abort_q, abort_d;

   logic [7:0]             lane_byte [NUM_LANES];
   logic [LANE_W-1:0]      pick_idle;
   logic [LANE_W-1:0]      pick_next;
   logic                   any_req;

   // First requester after 'last', wrapping; 'last' itself is checked last.
   // Both loops are constant so every index is static; smaller offsets win
   // because they are assigned last.
   function automatic logic [LANE_W-1:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                                 input logic [LANE_W-1:0]    last);
      logic [LANE_W-1:0] pick;
      pick = '0;
      for (int k = NUM_LANES; k >= 1; k--) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (last == LANE_W'(i) && req[(i + k) % NUM_LANES]) begin
               pick = LANE_W'((i + k) % NUM_LANES);
            end
         end
      end
      return pick;
   endfunction

   function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
      logic [NUM_LANES-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Slice the flat byte bus into one byte per lane.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_byte[i] = data_lane[8*i +: 8];
      end
   end

   assign any_req   = |valid_lane;
   assign pick_idle = rr_pick(valid_lane, last_q);
   // At word completion the finishing lane becomes the new round-robin reference.
   assign pick_next = rr_pick(valid_lane, gidx_q);

   // Next-state and output decode: grant hold, byte transfer, word completion and abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      data_d  = data_q;
      lane_d  = lane_q;
      valid_d = 1'b0;
      sow_d   = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               gidx_d  = pick_idle;
               grant_d = lane_onehot(pick_idle);
               cnt_d   = '0;
               state_d = S_BURST;
            end else begin
               grant_d = '0;
            end
         end
         S_BURST: begin
            if (valid_lane[gidx_q]) begin
               data_d  = lane_byte[gidx_q];
               lane_d  = gidx_q;
               valid_d = 1'b1;
               sow_d   = (cnt_q == '0);
               if (cnt_q == LAST_BYTE) begin
                  // Hand over on the same edge so the next word follows with no bubble.
                  last_d = gidx_q;
                  cnt_d  = '0;
                  if (any_req) begin
                     gidx_d  = pick_next;
                     grant_d = lane_onehot(pick_next);
                  end else begin
                     grant_d = '0;
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               // Withdraw: only a partially sent word needs the demux to resync.
               abort_d = (cnt_q != '0);
               grant_d = '0;
               last_d  = gidx_q;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset leaves lane 0 with top priority.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= RESET_LAST;
         gidx_q  <= '0;
         grant_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         lane_q  <= '0;
         sow_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         lane_q  <= lane_d;
         sow_q   <= sow_d;
         abort_q <= abort_d;
      end
   end

   assign grant_lane = grant_q;
   assign data_arb   = data_q;
   assign valid_arb  = valid_q;
   assign lane_arb   = lane_q;
   assign sow_arb    = sow_q;
   assign abort_arb  = abort_q;

endmodule

// File: tb/tb_arbitro_demux_8_32.sv
// Directed bench for arbitro_demux_8_32 with a word-level reference model.
// Sources are byte queues that hold their head byte until granted.
module tb_arbitro_demux_8_32;

   localparam int NL = 4;
   localparam int BPW = 4;

   logic          clk_4f = 1'b0;
   logic          reset = 1'b0;
   logic [NL-1:0] valid_lane = '0;
   logic [8*NL-1:0] data_lane = '0;
   logic [NL-1:0] grant_lane;
   logic [7:0]    data_arb;
   logic          valid_arb;
   logic [1:0]    lane_arb;
   logic          sow_arb;
   logic          abort_arb;

   arbitro_demux_8_32 #(.NUM_LANES(NL), .BYTES_PER_WORD(BPW), .LANE_W(2)) dut (
      .clk_4f     (clk_4f),
      .reset      (reset),
      .valid_lane (valid_lane),
      .data_lane  (data_lane),
      .grant_lane (grant_lane),
      .data_arb   (data_arb),
      .valid_arb  (valid_arb),
      .lane_arb   (lane_arb),
      .sow_arb    (sow_arb),
      .abort_arb  (abort_arb)
   );

   always #5 clk_4f = ~clk_4f;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- byte sources ----------------
   logic [7:0]    src_mem [NL][16];
   int            src_head [NL] = '{default: 0};
   int            src_tail [NL] = '{default: 0};
   logic [NL-1:0] mute = '0;
   logic [NL-1:0] acc = '0;

   task automatic push(input int l, input logic [7:0] b);
      src_mem[l][src_tail[l]] = b;
      src_tail[l]++;
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NL; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
      end
      mute = '0;
      acc = '0;
      valid_lane = '0;
      data_lane = '0;
   endtask

   // Retire bytes accepted on the last edge, present the next ones, and note
   // which lane will be accepted on the coming edge.
   task automatic service();
      logic [NL-1:0]   vl;
      logic [8*NL-1:0] dl;
      vl = '0;
      dl = '0;
      for (int i = 0; i < NL; i++) if (acc[i]) src_head[i]++;
      for (int i = 0; i < NL; i++) begin
         if (src_head[i] < src_tail[i] && !mute[i]) begin
            vl[i] = 1'b1;
            dl[8*i +: 8] = src_mem[i][src_head[i]];
         end
      end
      valid_lane = vl;
      data_lane = dl;
      acc = grant_lane & vl;
   endtask

   task automatic tick();
      @(negedge clk_4f);
      #1;
      service();
   endtask

   // ---------------- reference model ----------------
   int         m_owner = -1;     // lane holding the grant, -1 when none
   int         m_pos = 0;        // bytes of the current word already sent
   int         m_last = NL - 1;  // lane that most recently finished or released
   logic [NL-1:0] e_grant = '0;
   logic       e_valid = 1'b0;
   logic       e_sow = 1'b0;
   logic       e_abort = 1'b0;
   logic [7:0] e_data = '0;
   int         e_lane = 0;

   function automatic int rr(input logic [NL-1:0] req, input int last);
      int r;
      r = -1;
      for (int k = NL; k >= 1; k--) if (req[(last + k) % NL]) r = (last + k) % NL;
      return r;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_pos = 0;
      m_last = NL - 1;
      e_grant = '0;
      e_valid = 1'b0;
      e_sow = 1'b0;
      e_abort = 1'b0;
      e_data = '0;
      e_lane = 0;
   endtask

   task automatic model_step();
      logic [NL-1:0] v;
      v = valid_lane;
      e_valid = 1'b0;
      e_sow = 1'b0;
      e_abort = 1'b0;
      if (m_owner < 0) begin
         if (v != 0) begin
            m_owner = rr(v, m_last);
            m_pos = 0;
         end
      end else if (v[m_owner]) begin
         e_valid = 1'b1;
         e_data = data_lane[8*m_owner +: 8];
         e_lane = m_owner;
         e_sow = (m_pos == 0);
         m_pos++;
         if (m_pos == BPW) begin
            m_last = m_owner;
            m_pos = 0;
            m_owner = rr(v, m_last);
         end
      end else begin
         e_abort = (m_pos != 0);
         m_last = m_owner;
         m_owner = -1;
         m_pos = 0;
      end
      e_grant = (m_owner < 0) ? '0 : NL'(1 << m_owner);
   endtask

   initial begin
      forever begin
         @(posedge clk_4f or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare and observation log ----------------
   typedef struct {
      int         cyc;
      int         lane;
      logic [7:0] data;
      logic       sow;
   } obs_t;

   obs_t obs [$];
   int   abort_log [$];
   int   cyc = 0;
   int   gnz = 0;

   initial begin
      forever begin
         @(negedge clk_4f);
         cyc++;
         if (!reset) begin
            chk("grant", grant_lane, e_grant);
            chk("valid", valid_arb, e_valid);
            chk("sow", sow_arb, e_sow);
            chk("abort", abort_arb, e_abort);
            if (e_valid) begin
               chk("data", data_arb, e_data);
               chk("lane", lane_arb, e_lane);
            end
            chk("valid_abort_excl", valid_arb & abort_arb, 0);
            if (valid_arb) obs.push_back('{cyc, int'(lane_arb), data_arb, sow_arb});
            if (abort_arb) abort_log.push_back(cyc);
            if (grant_lane != 0) gnz++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   logic [7:0] t2_dat [16] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
                               8'h05, 8'h06, 8'h07, 8'h08, 8'h15, 8'h16, 8'h17, 8'h18};
   int         t2_lane [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
   logic [7:0] t3_dat [6] = '{8'h11, 8'h22, 8'h41, 8'h42, 8'h43, 8'h44};
   int         t3_lane [6] = '{3, 3, 0, 0, 0, 0};
   logic [7:0] t4_dat [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h55, 8'h56, 8'h57, 8'h58};
   int         t4_lane [8] = '{2, 2, 2, 2, 1, 1, 1, 1};

   initial begin
      int   s;
      int   a;
      int   g;
      logic found;

      #1 reset = 1'b1;
      #3;
      chk("rst_grant", grant_lane, 0);
      chk("rst_data", data_arb, 0);
      chk("rst_valid", valid_arb, 0);
      chk("rst_lane", lane_arb, 0);
      chk("rst_sow", sow_arb, 0);
      chk("rst_abort", abort_arb, 0);
      repeat (2) tick();
      reset = 1'b0;

      // Lanes 0 and 1 busy from reset: words alternate 0,1,0,1 with no gap.
      s = obs.size();
      for (int j = 0; j < 8; j++) begin
         push(0, 8'h01 + 8'(j));
         push(1, 8'h11 + 8'(j));
      end
      tick();
      tick();
      chk("t2_first_grant", grant_lane, 4'b0001);
      repeat (24) tick();
      chk("t2_count", obs.size() - s, 16);
      for (int j = 0; j < 16; j++) begin
         if (s + j < obs.size()) begin
            chk("t2_data", obs[s+j].data, t2_dat[j]);
            chk("t2_lane", obs[s+j].lane, t2_lane[j]);
            chk("t2_sow", obs[s+j].sow, (j % 4 == 0));
            chk("t2_gap", obs[s+j].cyc - obs[s].cyc, j);
         end
      end
      chk("t2_end_grant", grant_lane, 0);

      // Lane 2 alone.
      s = obs.size();
      for (int j = 0; j < 4; j++) push(2, 8'hA1 + 8'(j));
      tick();
      tick();
      chk("t1_grant", grant_lane, 4'b0100);
      repeat (10) tick();
      chk("t1_count", obs.size() - s, 4);
      for (int j = 0; j < 4; j++) begin
         if (s + j < obs.size()) begin
            chk("t1_data", obs[s+j].data, 8'hA1 + 8'(j));
            chk("t1_lane", obs[s+j].lane, 2);
            chk("t1_sow", obs[s+j].sow, (j == 0));
            chk("t1_gap", obs[s+j].cyc - obs[s].cyc, j);
         end
      end
      chk("t1_end_grant", grant_lane, 0);

      // Lane 3 withdraws after two bytes; lane 0 waiting takes over.
      s = obs.size();
      a = abort_log.size();
      push(3, 8'h11);
      push(3, 8'h22);
      for (int j = 0; j < 4; j++) push(0, 8'h41 + 8'(j));
      tick();
      tick();
      chk("t3_grant", grant_lane, 4'b1000);
      repeat (14) tick();
      chk("t3_aborts", abort_log.size() - a, 1);
      chk("t3_count", obs.size() - s, 6);
      for (int j = 0; j < 6; j++) begin
         if (s + j < obs.size()) begin
            chk("t3_data", obs[s+j].data, t3_dat[j]);
            chk("t3_lane", obs[s+j].lane, t3_lane[j]);
         end
      end
      if (abort_log.size() > a && obs.size() > s + 2) begin
         chk("t3_abort_cycle", abort_log[a], obs[s+1].cyc + 1);
         chk("t3_sow_after", obs[s+2].sow, 1);
      end

      // Lane 1 granted but idle in its first granted cycle: silent release.
      s = obs.size();
      a = abort_log.size();
      for (int j = 0; j < 4; j++) push(1, 8'h55 + 8'(j));
      tick();
      mute[1] = 1'b1;
      tick();
      chk("t4_grant1", grant_lane, 4'b0010);
      mute[1] = 1'b0;
      for (int j = 0; j < 4; j++) push(2, 8'h61 + 8'(j));
      tick();
      chk("t4_released", grant_lane, 0);
      chk("t4_no_valid", valid_arb, 0);
      tick();
      chk("t4_next_grant", grant_lane, 4'b0100);
      repeat (14) tick();
      chk("t4_aborts", abort_log.size() - a, 0);
      chk("t4_count", obs.size() - s, 8);
      for (int j = 0; j < 8; j++) begin
         if (s + j < obs.size()) begin
            chk("t4_data", obs[s+j].data, t4_dat[j]);
            chk("t4_lane", obs[s+j].lane, t4_lane[j]);
         end
      end

      // Asynchronous reset while the third byte of a word is on the output.
      for (int j = 0; j < 4; j++) push(0, 8'h31 + 8'(j));
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if (valid_arb && data_arb == 8'h33) found = 1'b1;
      end
      chk("t5_byte3_seen", found, 1);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_grant", grant_lane, 0);
      chk("t5_rst_data", data_arb, 0);
      chk("t5_rst_valid", valid_arb, 0);
      chk("t5_rst_lane", lane_arb, 0);
      chk("t5_rst_sow", sow_arb, 0);
      chk("t5_rst_abort", abort_arb, 0);
      clear_sources();
      repeat (2) tick();
      reset = 1'b0;
      s = obs.size();
      for (int j = 0; j < 4; j++) begin
         push(0, 8'h01 + 8'(j));
         push(2, 8'h71 + 8'(j));
      end
      tick();
      tick();
      chk("t5_first_grant", grant_lane, 4'b0001);
      repeat (14) tick();
      chk("t5_count", obs.size() - s, 8);
      if (obs.size() >= s + 8) begin
         chk("t5_w0_lane", obs[s].lane, 0);
         chk("t5_w1_lane", obs[s+4].lane, 2);
         chk("t5_w1_data", obs[s+4].data, 8'h71);
      end

      // Nothing requested for 20 cycles.
      s = obs.size();
      a = abort_log.size();
      g = gnz;
      repeat (20) tick();
      chk("t6_valid_cycles", obs.size() - s, 0);
      chk("t6_abort_cycles", abort_log.size() - a, 0);
      chk("t6_grant_cycles", gnz - g, 0);
      chk("t6_grant", grant_lane, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
